// File: rtl/a_block_stimuli_bank.sv
// Multi-channel stimulus RAM bank: loads and reads back vectors over a 16-bit word
// stream in IDLE, then plays them out one vector per capture strobe.
module a_block_stimuli_bank #(
  parameter int N_CH   = 2,
  parameter int CH_W   = 48,
  parameter int ADDR_W = 10
) (
  input  logic                   clk_ref,
  input  logic                   rst_n,
  input  logic [3:0]             ch_sel_i,
  input  logic                   load_start_i,
  input  logic                   wr_dv_i,
  input  logic [15:0]            wr_data_i,
  input  logic                   rd_req_i,
  output logic                   rd_dv_o,
  output logic [15:0]            rd_data_o,
  input  logic                   run_i,
  input  logic                   step_i,
  input  logic                   loop_i,
  input  logic [ADDR_W-1:0]      last_addr_i,
  output logic [N_CH*CH_W-1:0]   vec_o,
  output logic [ADDR_W-1:0]      addr_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   ovf_o,
  output logic                   err_o
);

  localparam int K     = (CH_W + 15) / 16;
  localparam int KW    = (K > 1) ? $clog2(K) : 1;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int VW    = K * 16;
  localparam logic [4:0]        N_CH_L   = 5'(N_CH);
  localparam logic [KW-1:0]     K_LAST   = KW'(K - 1);
  localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, PRIME, PLAY, DONE} state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;

  logic [KW-1:0]     wr_k_reg, rd_k_reg;
  logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic              wr_full_reg;
  logic [VW-1:0]     wr_buf_reg;
  logic              ovf_reg, err_reg;

  logic              rb_v_reg;
  logic [3:0]        rb_ch_reg;
  logic [KW-1:0]     rb_k_reg;
  logic              rd_dv_reg;
  logic [15:0]       rd_data_reg;

  logic              is_idle, ch_ok, wr_take, rd_take, proto_err, play_rd;
  logic [KW-1:0]     wr_k_eff, rd_k_eff;
  logic [ADDR_W-1:0] wr_ptr_eff, rd_ptr_eff;
  logic              wr_full_eff, wr_last, wr_commit;
  logic [VW-1:0]     wr_asm;
  logic [CH_W-1:0]   wr_vec;
  logic [CH_W-1:0]   rb_word [N_CH];
  logic [CH_W-1:0]   rb_sel;
  logic [VW-1:0]     rb_ext;
  logic [15:0]       rb_out;

  assign is_idle   = (state_reg == IDLE);
  assign ch_ok     = ({1'b0, ch_sel_i} < N_CH_L);
  assign wr_take   = is_idle & wr_dv_i & ch_ok;
  assign rd_take   = is_idle & rd_req_i & ~wr_dv_i & ch_ok;
  assign proto_err = (~is_idle & (wr_dv_i | rd_req_i)) | (is_idle & wr_dv_i & rd_req_i);
  assign play_rd   = run_i & ((state_reg == PRIME) | (state_reg == PLAY));

  // load_start clears first, so a word arriving with it lands as word 0 at address 0
  assign wr_k_eff    = load_start_i ? '0 : wr_k_reg;
  assign rd_k_eff    = load_start_i ? '0 : rd_k_reg;
  assign wr_ptr_eff  = load_start_i ? '0 : wr_ptr_reg;
  assign rd_ptr_eff  = load_start_i ? '0 : rd_ptr_reg;
  assign wr_full_eff = load_start_i ? 1'b0 : wr_full_reg;
  assign wr_last     = wr_take & (wr_k_eff == K_LAST);
  assign wr_commit   = wr_last & ~wr_full_eff;

  always_comb begin
    wr_asm = wr_buf_reg;
    wr_asm[{wr_k_eff, 4'b0000} +: 16] = wr_data_i;
  end
  assign wr_vec = wr_asm[CH_W-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CH_W-1:0] mem [DEPTH];
      logic [CH_W-1:0] play_q_reg;
      logic [CH_W-1:0] rb_q_reg;

      always_ff @(posedge clk_ref) begin
        if (wr_commit && (ch_sel_i == 4'(gi)))
          mem[wr_ptr_eff] <= wr_vec;
      end

      always_ff @(posedge clk_ref) begin
        if (!rst_n)
          play_q_reg <= '0;
        else if (play_rd)
          play_q_reg <= mem[addr_reg];
      end

      always_ff @(posedge clk_ref) begin
        if (!rst_n)
          rb_q_reg <= '0;
        else if (rd_take)
          rb_q_reg <= mem[rd_ptr_eff];
      end

      assign vec_o[gi*CH_W +: CH_W] = play_q_reg;
      assign rb_word[gi]            = rb_q_reg;
    end
  endgenerate

  always_comb begin
    rb_sel = '0;
    for (int c = 0; c < N_CH; c++)
      if (rb_ch_reg == 4'(c))
        rb_sel = rb_word[c];
    rb_ext = '0;
    rb_ext[CH_W-1:0] = rb_sel;
    rb_out = rb_ext[{rb_k_reg, 4'b0000} +: 16];
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      wr_k_reg    <= '0;
      rd_k_reg    <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      wr_full_reg <= 1'b0;
      wr_buf_reg  <= '0;
      ovf_reg     <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      wr_k_reg    <= wr_k_eff;
      rd_k_reg    <= rd_k_eff;
      wr_ptr_reg  <= wr_ptr_eff;
      rd_ptr_reg  <= rd_ptr_eff;
      wr_full_reg <= wr_full_eff;
      if (wr_take) begin
        wr_buf_reg <= wr_asm;
        if (wr_last) begin
          wr_k_reg <= '0;
          // the last address stays writable once; only a write beyond it overflows
          if (wr_full_eff)
            ovf_reg <= 1'b1;
          else if (wr_ptr_eff == ADDR_MAX)
            wr_full_reg <= 1'b1;
          else
            wr_ptr_reg <= wr_ptr_eff + 1'b1;
        end else begin
          wr_k_reg <= wr_k_eff + 1'b1;
        end
      end
      if (rd_take) begin
        if (rd_k_eff == K_LAST) begin
          rd_k_reg   <= '0;
          rd_ptr_reg <= rd_ptr_eff + 1'b1;
        end else begin
          rd_k_reg <= rd_k_eff + 1'b1;
        end
      end
      if (proto_err)
        err_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      rb_v_reg    <= 1'b0;
      rb_ch_reg   <= '0;
      rb_k_reg    <= '0;
      rd_dv_reg   <= 1'b0;
      rd_data_reg <= '0;
    end else begin
      rb_v_reg  <= rd_take;
      rd_dv_reg <= rb_v_reg;
      if (rd_take) begin
        rb_ch_reg <= ch_sel_i;
        rb_k_reg  <= rd_k_eff;
      end
      if (rb_v_reg)
        rd_data_reg <= rb_out;
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    if (!is_idle && !run_i) begin
      state_next = IDLE;
      addr_next  = '0;
    end else begin
      case (state_reg)
        IDLE:  if (run_i) state_next = PRIME;
        PRIME: state_next = PLAY;
        PLAY: begin
          if (step_i) begin
            if (addr_reg == last_addr_i) begin
              if (loop_i)
                addr_next = '0;
              else
                state_next = DONE;
            end else begin
              addr_next = addr_reg + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_ref) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
    end
  end

  assign addr_o    = addr_reg;
  assign busy_o    = (state_reg == PRIME) | (state_reg == PLAY);
  assign done_o    = (state_reg == DONE);
  assign ovf_o     = ovf_reg;
  assign err_o     = err_reg;
  assign rd_dv_o   = rd_dv_reg;
  assign rd_data_o = rd_data_reg;

endmodule

// File: tb/tb_a_block_stimuli_bank.sv
// Bench for a_block_stimuli_bank: behavioural model compared every cycle, plus
// hand-computed expectations and an overflow check on a shallow second instance.
module tb_a_block_stimuli_bank;

  localparam int N_CH   = 2;
  localparam int CH_W   = 48;
  localparam int ADDR_W = 10;
  localparam int K      = 3;
  localparam int DEPTH  = 1024;

  logic              clk_ref = 1'b0;
  logic              rst_n;
  logic [3:0]        ch_sel;
  logic              load_start, wr_dv, rd_req, run, step, loop_m;
  logic [15:0]       wr_data;
  logic [ADDR_W-1:0] last_addr;
  logic              rd_dv, busy, done, ovf, err;
  logic [15:0]       rd_data;
  logic [N_CH*CH_W-1:0] vec;
  logic [ADDR_W-1:0] addr;

  logic              s_load_start, s_wr_dv, s_rd_req;
  logic [15:0]       s_wr_data;
  logic              s_rd_dv, s_busy, s_done, s_ovf, s_err;
  logic [15:0]       s_rd_data;
  logic [N_CH*CH_W-1:0] s_vec;
  logic [1:0]        s_addr;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk_ref = ~clk_ref;

  a_block_stimuli_bank #(.N_CH(N_CH), .CH_W(CH_W), .ADDR_W(ADDR_W)) dut (
    .clk_ref(clk_ref), .rst_n(rst_n), .ch_sel_i(ch_sel), .load_start_i(load_start),
    .wr_dv_i(wr_dv), .wr_data_i(wr_data), .rd_req_i(rd_req), .rd_dv_o(rd_dv),
    .rd_data_o(rd_data), .run_i(run), .step_i(step), .loop_i(loop_m),
    .last_addr_i(last_addr), .vec_o(vec), .addr_o(addr), .busy_o(busy),
    .done_o(done), .ovf_o(ovf), .err_o(err)
  );

  a_block_stimuli_bank #(.N_CH(N_CH), .CH_W(CH_W), .ADDR_W(2)) dut_small (
    .clk_ref(clk_ref), .rst_n(rst_n), .ch_sel_i(4'd0), .load_start_i(s_load_start),
    .wr_dv_i(s_wr_dv), .wr_data_i(s_wr_data), .rd_req_i(s_rd_req), .rd_dv_o(s_rd_dv),
    .rd_data_o(s_rd_data), .run_i(1'b0), .step_i(1'b0), .loop_i(1'b0),
    .last_addr_i(2'd0), .vec_o(s_vec), .addr_o(s_addr), .busy_o(s_busy),
    .done_o(s_done), .ovf_o(s_ovf), .err_o(s_err)
  );

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: state 0=IDLE 1=PRIME 2=PLAY 3=DONE
  logic [CH_W-1:0] m_mem [N_CH][DEPTH];
  logic [CH_W-1:0] m_vec [N_CH];
  logic [15:0]     m_words [K];
  int              m_st, m_addr, m_wk, m_rk, m_rptr, m_wcount;
  bit              m_err, m_ovf, exp_rd_dv, p_v, nv;
  logic [15:0]     exp_rd_data, p_d, nd;
  logic [K*16-1:0] m_asm;

  always @(posedge clk_ref) begin
    if (!rst_n) begin
      m_st = 0; m_addr = 0; m_wk = 0; m_rk = 0; m_rptr = 0; m_wcount = 0;
      m_err = 0; m_ovf = 0; exp_rd_dv = 0; exp_rd_data = '0; p_v = 0; p_d = '0;
      for (int c = 0; c < N_CH; c++) m_vec[c] = '0;
    end else begin
      nv = 0; nd = '0;
      if ((m_st != 0 && (wr_dv || rd_req)) || (m_st == 0 && wr_dv && rd_req)) m_err = 1;
      if (load_start) begin m_wk = 0; m_rk = 0; m_rptr = 0; m_wcount = 0; end
      if (m_st == 0 && int'(ch_sel) < N_CH) begin
        if (wr_dv) begin
          m_words[m_wk] = wr_data;
          m_wk++;
          if (m_wk == K) begin
            m_wk = 0;
            for (int w = 0; w < K; w++) m_asm[16*w +: 16] = m_words[w];
            if (m_wcount >= DEPTH) m_ovf = 1;
            else m_mem[ch_sel][m_wcount] = m_asm[CH_W-1:0];
            m_wcount++;
          end
        end else if (rd_req) begin
          nd = 16'(m_mem[ch_sel][m_rptr] >> (16 * m_rk));
          nv = 1;
          m_rk++;
          if (m_rk == K) begin m_rk = 0; m_rptr = (m_rptr + 1) % DEPTH; end
        end
      end
      exp_rd_dv = p_v;
      if (p_v) exp_rd_data = p_d;
      p_v = nv; p_d = nd;
      if (!run) begin
        m_st = 0; m_addr = 0;
      end else begin
        if (m_st == 1 || m_st == 2)
          for (int c = 0; c < N_CH; c++) m_vec[c] = m_mem[c][m_addr];
        case (m_st)
          0: m_st = 1;
          1: m_st = 2;
          2: if (step) begin
               if (m_addr == int'(last_addr)) begin
                 if (loop_m) m_addr = 0; else m_st = 3;
               end else m_addr++;
             end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk_ref) begin
    check("vec", 128'(vec), 128'({m_vec[1], m_vec[0]}));
    check("addr", 128'(addr), 128'(m_addr));
    check("busy", 128'(busy), 128'(m_st == 1 || m_st == 2));
    check("done", 128'(done), 128'(m_st == 3));
    check("ovf", 128'(ovf), 128'(m_ovf));
    check("err", 128'(err), 128'(m_err));
    check("rd_dv", 128'(rd_dv), 128'(exp_rd_dv));
    if (exp_rd_dv) check("rd_data", 128'(rd_data), 128'(exp_rd_data));
  end

  task automatic cyc();
    @(negedge clk_ref);
    load_start = 1'b0;
  endtask

  task automatic load_vec(input int ch, input logic [CH_W-1:0] v);
    for (int w = 0; w < K; w++) begin
      ch_sel = 4'(ch); wr_dv = 1'b1; wr_data = v[16*w +: 16];
      cyc();
    end
    wr_dv = 1'b0;
  endtask

  task automatic rd_check(input int ch, input logic [15:0] exp);
    ch_sel = 4'(ch); rd_req = 1'b1;
    cyc();
    rd_req = 1'b0;
    check("rd_dv_early", 128'(rd_dv), 128'(0));
    cyc();
    check("rd_dv_lat2", 128'(rd_dv), 128'(1));
    check("rd_word", 128'(rd_data), 128'(exp));
  endtask

  int              seq[6] = '{1, 2, 3, 0, 1, 2};
  logic [N_CH*CH_W-1:0] saved;
  logic [15:0]     w0;
  int              nreq;

  initial begin
    rst_n = 1'b0; ch_sel = '0; load_start = 0; wr_dv = 0; rd_req = 0; run = 0;
    step = 0; loop_m = 0; wr_data = '0; last_addr = '0;
    s_load_start = 0; s_wr_dv = 0; s_rd_req = 0; s_wr_data = '0;
    repeat (3) cyc();
    check("rst_vec", 128'(vec), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst_n = 1'b1;
    cyc();

    // overflow on a 4-deep bank
    s_load_start = 1; cyc(); s_load_start = 0;
    for (int n = 0; n < 5; n++) begin
      for (int w = 0; w < K; w++) begin
        s_wr_dv = 1;
        s_wr_data = (w == 0) ? 16'(n) : ((w == 1) ? 16'h5555 : 16'h6666);
        cyc();
      end
      s_wr_dv = 0;
      if (n == 3) check("small_ovf_4th", 128'(s_ovf), 128'(0));
      if (n == 4) check("small_ovf_5th", 128'(s_ovf), 128'(1));
    end
    s_load_start = 1; cyc(); s_load_start = 0;
    for (int w = 0; w < K; w++) begin
      s_rd_req = 1; cyc(); s_rd_req = 0; cyc();
      check("small_rd_dv", 128'(s_rd_dv), 128'(1));
      check("small_rd_word", 128'(s_rd_data),
            128'((w == 0) ? 16'h0000 : ((w == 1) ? 16'h5555 : 16'h6666)));
    end

    // directed load; first word rides with load_start
    load_start = 1;
    for (int n = 0; n < 4; n++) load_vec(0, 48'h1111_2222_0000 + 48'(n));
    load_start = 1; cyc();
    for (int n = 0; n < 4; n++) load_vec(1, 48'hAAAA_BBBB_0000 + 48'(n));
    load_start = 1; cyc();
    for (int j = 0; j < 12; j++)
      rd_check(1, (j % 3 == 0) ? 16'(j / 3) : ((j % 3 == 1) ? 16'hBBBB : 16'hAAAA));

    // play once, no loop
    last_addr = 10'd3; loop_m = 0; run = 1; step = 1;
    cyc();
    check("prime_busy", 128'(busy), 128'(1));
    cyc();
    check("vec0_after_run", 128'(vec[47:0]), 128'(48'h1111_2222_0000));
    repeat (6) cyc();
    check("done_noloop", 128'(done), 128'(1));
    check("addr_noloop", 128'(addr), 128'(3));
    check("vec_hold_ch0", 128'(vec[47:0]), 128'(48'h1111_2222_0003));
    check("vec_hold_ch1", 128'(vec[95:48]), 128'(48'hAAAA_BBBB_0003));
    run = 0; step = 0; cyc();

    // loop mode
    loop_m = 1; run = 1; cyc(); cyc();
    for (int j = 0; j < 6; j++) begin
      step = 1; cyc();
      check("loop_addr", 128'(addr), 128'(seq[j]));
      check("loop_done", 128'(done), 128'(0));
    end
    step = 0;

    // abort together with a step
    saved = vec; run = 0; step = 1; cyc();
    check("abort_addr", 128'(addr), 128'(0));
    check("abort_busy", 128'(busy), 128'(0));
    check("abort_vec", 128'(vec), 128'(saved));
    step = 0;

    // write attempt during play
    run = 1; cyc(); cyc();
    ch_sel = 0; wr_dv = 1; wr_data = 16'hDEAD; cyc(); wr_dv = 0;
    check("err_play_wr", 128'(err), 128'(1));
    run = 0; cyc();
    load_start = 1; cyc();
    rd_check(0, 16'h0000); rd_check(0, 16'h2222); rd_check(0, 16'h1111);

    // reset mid-play
    run = 1; step = 1; last_addr = 10'd3; loop_m = 1;
    repeat (4) cyc();
    rst_n = 0; run = 0; step = 0; cyc();
    check("rst_vec_mid", 128'(vec), 128'(0));
    check("rst_addr_mid", 128'(addr), 128'(0));
    check("rst_busy_mid", 128'(busy), 128'(0));
    check("rst_err_mid", 128'(err), 128'(0));
    check("rst_rd_dv_mid", 128'(rd_dv), 128'(0));
    rst_n = 1; cyc();

    // write and read collide in IDLE
    ch_sel = 0; wr_dv = 1; rd_req = 1; wr_data = 16'h1234; cyc();
    wr_dv = 0; rd_req = 0;
    check("err_collide", 128'(err), 128'(1));
    cyc(); cyc();
    check("collide_no_rd", 128'(rd_dv), 128'(0));

    // random load of 16 vectors per channel
    load_start = 1; cyc();
    for (int c = 0; c < N_CH; c++) begin
      load_start = 1; cyc();
      for (int n = 0; n < 16; n++) begin
        for (int w = 0; w < K; w++) begin
          ch_sel = 4'(c); wr_dv = 1; wr_data = 16'($urandom);
          cyc();
          wr_dv = 0;
          if ($urandom_range(0, 2) == 0) cyc();
        end
      end
    end

    // random playback episodes
    for (int e = 0; e < 14; e++) begin
      last_addr = 10'($urandom_range(0, 15));
      loop_m = 1'($urandom_range(0, 1));
      run = 1;
      for (int t = 0; t < 30; t++) begin
        step = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 39) == 0) begin
          ch_sel = 0; wr_dv = 1; wr_data = 16'($urandom);
        end
        cyc();
        wr_dv = 0;
      end
      run = 0; step = 1'($urandom_range(0, 1));
      cyc();
      step = 0;
      cyc();
    end

    // random pipelined readback, including ignored channel selects
    load_start = 1; cyc();
    nreq = 0;
    while (nreq < 45) begin
      ch_sel = 4'($urandom_range(0, 3));
      rd_req = 1'($urandom_range(0, 1));
      if (rd_req && ch_sel < 2) nreq++;
      cyc();
    end
    rd_req = 0;
    repeat (4) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
